// File: rtl/riscv_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle
// Purpose  : Multicycle RV32I-subset core. A FETCH/DECODE/EXEC/MEM/WB state
//            machine sequences one shared ALU. Instruction and data memories
//            are external and reached through req/ready handshakes, so either
//            side may insert wait states.
// Ports    : clk, reset (synchronous, active-high)
//            imem_req/imem_addr/imem_ready/imem_rdata : instruction fetch port
//            dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ready/dmem_rdata :
//                                                       data access port
//            pc      : current word-index program counter
//            retire  : one-cycle pulse in the last cycle of each instruction
//            halted  : sticky, set on an illegal/unsupported instruction
// Revision : 1.0 - initial release
// ============================================================================
module riscv_multicycle #(
    parameter int              XLEN     = 32,
    parameter int              PC_W     = 8,
    parameter int              DADDR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_ready,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               retire,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_aluout;
    logic [XLEN-1:0]   r_mdr;
    logic              r_halted;
    logic [XLEN-1:0]   r_regs [32];

    // ------------------------------------------------------------------
    // Instruction fields and class decode (IR is stable from DECODE on)
    // ------------------------------------------------------------------
    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    logic              w_is_r;
    logic              w_is_i;
    logic              w_is_lw;
    logic              w_is_sw;
    logic              w_is_br;
    logic              w_legal;
    logic              w_f3_alu;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_rd     = r_ir[11:7];

    // funct3 values shared by R and I ALU groups: add/sub, slt, or, and
    assign w_f3_alu = (w_funct3 == 3'b000) || (w_funct3 == 3'b010) ||
                      (w_funct3 == 3'b110) || (w_funct3 == 3'b111);

    assign w_is_r   = (w_opcode == 7'b0110011) &&
                      (((w_funct7 == 7'b0000000) && w_f3_alu) ||
                       ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)));
    assign w_is_i   = (w_opcode == 7'b0010011) && w_f3_alu;
    assign w_is_lw  = (w_opcode == 7'b0000011) && (w_funct3 == 3'b010);
    assign w_is_sw  = (w_opcode == 7'b0100011) && (w_funct3 == 3'b010);
    assign w_is_br  = (w_opcode == 7'b1100011) && (w_funct3[2:1] == 2'b00);
    assign w_legal  = w_is_r || w_is_i || w_is_lw || w_is_sw || w_is_br;

    // ------------------------------------------------------------------
    // Immediate generation. The branch offset is the 12-bit B-type field
    // {ir[31],ir[7],ir[30:25],ir[11:8]} used directly as a word count,
    // matching the word-addressed PC of the previous core.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_imm;

    always_comb begin
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        if (w_is_sw) begin
            w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        end else if (w_is_br) begin
            w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8]};
        end
    end

    // ------------------------------------------------------------------
    // Shared ALU: loads and stores always add, otherwise funct3 selects
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_alu_b;
    logic [XLEN-1:0]   w_alu;
    logic              w_taken;

    assign w_alu_b = w_is_r ? r_b : w_imm;

    always_comb begin
        w_alu = r_a + w_alu_b;
        if (!(w_is_lw || w_is_sw)) begin
            case (w_funct3)
                3'b000:  if (w_is_r && r_ir[30]) w_alu = r_a - w_alu_b;
                3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
                3'b110:  w_alu = r_a | w_alu_b;
                3'b111:  w_alu = r_a & w_alu_b;
                default: w_alu = r_a + w_alu_b;
            endcase
        end
    end

    // funct3[0] distinguishes bne from beq
    assign w_taken = (r_a == r_b) ^ w_funct3[0];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (w_is_br) begin
                    retire = 1'b1;
                    w_next = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_sw;
                if (dmem_ready) begin
                    retire = w_is_sw;
                    w_next = w_is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
        // Requests and retire are suppressed for the whole reset period,
        // not only after the first reset edge.
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            retire   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_halted <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) r_ir <= imem_rdata;
                end
                S_DECODE: begin
                    r_a <= (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
                    r_b <= (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
                    if (!w_legal) r_halted <= 1'b1;
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                    if (w_is_br) begin
                        r_pc <= w_taken ? (r_pc + w_imm[PC_W-1:0]) : (r_pc + PC_W'(1));
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_sw) begin
                            r_pc <= r_pc + PC_W'(1);
                        end else begin
                            r_mdr <= dmem_rdata;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) begin
                        r_regs[w_rd] <= w_is_lw ? r_mdr : r_aluout;
                    end
                    r_pc <= r_pc + PC_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign dmem_addr  = r_aluout[DADDR_W-1:0];
    assign dmem_wdata = r_b;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multicycle
// Purpose  : Self-checking bench for riscv_multicycle. An instruction-level
//            model predicts the PC, memory traffic, retire latency and halt
//            of every instruction; a compare process checks the DUT against
//            it each cycle, and literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [7:0]  pc;
    logic        retire;
    logic        halted;

    riscv_multicycle #(
        .XLEN(32), .PC_W(8), .DADDR_W(8), .RESET_PC(8'd0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] prog    [256];
    logic [31:0] dmem_arr[256];
    int          iwait   [256];
    int          dwait   [256];

    // captures for literal checks
    logic [31:0] st_wdata [256];
    logic [7:0]  st_addr  [256];
    int          lat_cap  [256];
    logic [7:0]  next_addr[256];
    int          dreq_cnt [256];

    // model state
    logic [31:0] m_x   [32];
    logic [31:0] m_dmem[256];
    logic [7:0]  m_pc;
    bit          m_halted;
    bit          active;
    bit          have_prev;
    logic [7:0]  prev_pc;
    int          t_start, t_halt, e_lat, e_kind, e_rd;
    bit          e_ill;
    logic [31:0] e_res, e_wdata;
    logic [7:0]  e_daddr, e_npc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1,
                                          input logic [2:0] f3);
        logic [11:0] v;
        v = 12'(off);
        return {v[11], v[9:4], 5'(rs2), 5'(rs1), f3, v[3:0], v[10], 7'h63};
    endfunction

    // ---------------- instruction-level model ----------------
    task automatic predict(input logic [31:0] ins);
        logic [31:0] a, b, ii, is, ib;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        a  = m_x[ins[19:15]];
        b  = m_x[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
        e_rd = int'(ins[11:7]); e_ill = 0; e_kind = 0; e_res = 0;
        e_daddr = 0; e_wdata = 0; e_npc = m_pc + 8'd1;
        case (ins[6:0])
            7'h33: begin
                if      (f7 == 7'h00 && f3 == 3'd0) e_res = a + b;
                else if (f7 == 7'h20 && f3 == 3'd0) e_res = a - b;
                else if (f7 == 7'h00 && f3 == 3'd7) e_res = a & b;
                else if (f7 == 7'h00 && f3 == 3'd6) e_res = a | b;
                else if (f7 == 7'h00 && f3 == 3'd2) e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else e_ill = 1;
            end
            7'h13: begin
                if      (f3 == 3'd0) e_res = a + ii;
                else if (f3 == 3'd7) e_res = a & ii;
                else if (f3 == 3'd6) e_res = a | ii;
                else if (f3 == 3'd2) e_res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                else e_ill = 1;
            end
            7'h03: if (f3 == 3'd2) begin e_kind = 1; e_daddr = 8'(a + ii); end else e_ill = 1;
            7'h23: if (f3 == 3'd2) begin e_kind = 2; e_daddr = 8'(a + is); e_wdata = b; end else e_ill = 1;
            7'h63: begin
                if (f3 == 3'd0 || f3 == 3'd1) begin
                    e_kind = 3;
                    if ((f3 == 3'd0) ? (a == b) : (a != b)) e_npc = m_pc + ib[7:0];
                end else e_ill = 1;
            end
            default: e_ill = 1;
        endcase
        e_lat = (e_kind == 3) ? 3 : (e_kind == 1) ? 5 : 4;
        e_lat += iwait[m_pc];
        if (e_kind == 1 || e_kind == 2) e_lat += dwait[m_pc];
        t_halt = t_start + iwait[m_pc] + 2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = 0;
        m_pc = 0; m_halted = 0; active = 0; have_prev = 0;
    endtask

    task automatic clear_caps();
        for (int i = 0; i < 256; i++) begin
            st_wdata[i] = 32'hDEADBEEF; st_addr[i] = 8'hEE; lat_cap[i] = -1;
            next_addr[i] = 8'hEE; dreq_cnt[i] = 0;
        end
    endtask

    // ---------------- cycle counter ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- memory responders ----------------
    initial begin
        int icnt;
        int dcnt;
        icnt = 0; dcnt = 0;
        forever begin
            @(posedge clk);
            if (!reset && dmem_req && dmem_ready && dmem_we) dmem_arr[dmem_addr] = dmem_wdata;
            #1;
            imem_rdata = prog[imem_addr];
            if (imem_req) begin
                imem_ready = (icnt >= iwait[imem_addr]);
                icnt = imem_ready ? 0 : icnt + 1;
            end else begin
                imem_ready = 0; icnt = 0;
            end
            dmem_rdata = dmem_arr[dmem_addr];
            if (dmem_req) begin
                dmem_ready = (dcnt >= dwait[pc]);
                dcnt = dmem_ready ? 0 : dcnt + 1;
            end else begin
                dmem_ready = 0; dcnt = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("outputs_in_reset", {28'd0, imem_req, dmem_req, dmem_we, retire}, 32'd0);
            model_reset();
        end else begin
            check("pc", {24'd0, pc}, {24'd0, m_pc});
            if (active && e_ill && cyc >= t_halt) m_halted = 1;
            check("halted", {31'd0, halted}, {31'd0, m_halted});
            if (m_halted) begin
                check("quiet_when_halted", {29'd0, imem_req, dmem_req, retire}, 32'd0);
            end else begin
                if (imem_req && !active) begin
                    active = 1;
                    t_start = cyc;
                    if (have_prev) next_addr[prev_pc] = imem_addr;
                    predict(prog[m_pc]);
                end
                if (imem_req) check("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
                if (dmem_req) begin
                    dreq_cnt[m_pc]++;
                    check("dmem_req_expected", {31'd0, active && (e_kind == 1 || e_kind == 2)}, 32'd1);
                    check("dmem_addr", {24'd0, dmem_addr}, {24'd0, e_daddr});
                    check("dmem_we", {31'd0, dmem_we}, {31'd0, e_kind == 2});
                    if (e_kind == 2) begin
                        check("dmem_wdata", dmem_wdata, e_wdata);
                        st_wdata[m_pc] = dmem_wdata;
                        st_addr[m_pc]  = dmem_addr;
                    end
                end
                if (retire) begin
                    check("retire_expected", {31'd0, active && !e_ill}, 32'd1);
                    check("latency", 32'(cyc - t_start + 1), 32'(e_lat));
                    lat_cap[m_pc] = cyc - t_start + 1;
                    if (e_kind == 0 && e_rd != 0) m_x[e_rd] = e_res;
                    if (e_kind == 1 && e_rd != 0) m_x[e_rd] = m_dmem[e_daddr];
                    if (e_kind == 2) m_dmem[e_daddr] = e_wdata;
                    prev_pc = m_pc; have_prev = 1;
                    m_pc = e_npc;
                    active = 0;
                end else if (active && !e_ill && (cyc - t_start) > 60) begin
                    check("retire_timeout", 32'd0, 32'd1);
                    active = 0;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1; imem_ready = 0; dmem_ready = 0; imem_rdata = 0; dmem_rdata = 0;
        for (int i = 0; i < 256; i++) begin
            prog[i] = 0; dmem_arr[i] = 0; m_dmem[i] = 0; iwait[i] = 0; dwait[i] = 0;
        end
        iwait[3] = 1; iwait[14] = 2; dwait[9] = 3; dwait[10] = 3;

        prog[0]  = enc_i(5, 0, 3'd0, 1, 7'h13);       // addi x1,x0,5
        prog[1]  = enc_i(7, 0, 3'd0, 2, 7'h13);       // addi x2,x0,7
        prog[2]  = enc_r(7'h00, 2, 1, 3'd0, 3);       // add  x3,x1,x2
        prog[3]  = enc_r(7'h20, 2, 1, 3'd0, 4);       // sub  x4,x1,x2
        prog[4]  = enc_r(7'h00, 1, 4, 3'd2, 5);       // slt  x5,x4,x1
        prog[5]  = enc_b(3, 1, 1, 3'd0);              // beq  x1,x1,+3
        prog[8]  = enc_b(3, 1, 1, 3'd1);              // bne  x1,x1,+3
        prog[9]  = enc_s(2, 3, 0);                    // sw   x3,2(x0)
        prog[10] = enc_i(2, 0, 3'd2, 6, 7'h03);       // lw   x6,2(x0)
        prog[11] = enc_s(3, 6, 0);                    // sw   x6,3(x0)
        prog[12] = enc_s(4, 4, 0);                    // sw   x4,4(x0)
        prog[13] = enc_s(5, 5, 0);                    // sw   x5,5(x0)
        prog[14] = enc_i(9, 0, 3'd0, 0, 7'h13);       // addi x0,x0,9
        prog[15] = enc_r(7'h00, 0, 0, 3'd0, 7);       // add  x7,x0,x0
        prog[16] = enc_s(6, 7, 0);                    // sw   x7,6(x0)
        prog[17] = enc_i(240, 4, 3'd7, 8, 7'h13);     // andi x8,x4,0xF0
        prog[18] = enc_i(48, 1, 3'd6, 9, 7'h13);      // ori  x9,x1,0x30
        prog[19] = enc_i(-1, 4, 3'd2, 10, 7'h13);     // slti x10,x4,-1
        prog[20] = enc_r(7'h00, 2, 4, 3'd7, 11);      // and  x11,x4,x2
        prog[21] = enc_r(7'h00, 2, 1, 3'd6, 12);      // or   x12,x1,x2
        for (int i = 0; i < 5; i++) prog[22 + i] = enc_s(7 + i, 8 + i, 0);
        prog[27] = enc_b(3, 2, 1, 3'd0);              // beq  x1,x2 (not taken)
        prog[28] = 32'h0000_0000;                     // illegal -> halt
        clear_caps();
        model_reset();

        // reset for two edges
        repeat (2) @(negedge clk);
        #1 check("imem_req_during_reset", {31'd0, imem_req}, 32'd0);
        reset = 0;
        #1;
        check("first_imem_req", {31'd0, imem_req}, 32'd1);
        check("first_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("first_pc", {24'd0, pc}, 32'd0);
        check("first_halted", {31'd0, halted}, 32'd0);

        for (int i = 0; i < 1500 && halted !== 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);

        check("halt_reached", {31'd0, halted}, 32'd1);
        check("halt_pc", {24'd0, pc}, 32'd28);
        check("lat_addi", 32'(lat_cap[0]), 32'd4);
        check("lat_sub_iwait1", 32'(lat_cap[3]), 32'd5);
        check("lat_beq", 32'(lat_cap[5]), 32'd3);
        check("lat_sw_dwait3", 32'(lat_cap[9]), 32'd7);
        check("lat_lw_dwait3", 32'(lat_cap[10]), 32'd8);
        check("lat_addi_iwait2", 32'(lat_cap[14]), 32'd6);
        check("beq_target", {24'd0, next_addr[5]}, 32'd8);
        check("bne_fallthru", {24'd0, next_addr[8]}, 32'd9);
        check("beq_not_taken", {24'd0, next_addr[27]}, 32'd28);
        check("sw_x3_addr", {24'd0, st_addr[9]}, 32'd2);
        check("sw_x3_data", st_wdata[9], 32'd12);
        check("sw_dreq_cycles", 32'(dreq_cnt[9]), 32'd4);
        check("lw_dreq_cycles", 32'(dreq_cnt[10]), 32'd4);
        check("x6_loaded", st_wdata[11], 32'd12);
        check("x4_sub", st_wdata[12], 32'hFFFF_FFFE);
        check("x5_slt", st_wdata[13], 32'd1);
        check("x7_x0_write", st_wdata[16], 32'd0);
        check("x8_andi", st_wdata[22], 32'h0000_00F0);
        check("x9_ori", st_wdata[23], 32'h0000_0035);
        check("x10_slti", st_wdata[24], 32'd1);
        check("x11_and", st_wdata[25], 32'd6);
        check("x12_or", st_wdata[26], 32'd7);

        // rerun, then abort with reset in the middle of the sw at pc 9
        #1 reset = 1;
        clear_caps();
        @(negedge clk);
        #1 reset = 0;
        for (int i = 0; i < 500 && !(dmem_req === 1'b1 && pc == 8'd9); i++) @(negedge clk);
        check("reached_mem_pc9", {31'd0, dmem_req}, 32'd1);
        #1 reset = 1;
        #1;
        check("dmem_req_abort", {31'd0, dmem_req}, 32'd0);
        check("dmem_we_abort", {31'd0, dmem_we}, 32'd0);

        prog[0] = enc_s(0, 1, 0);                     // sw x1,0(x0)
        prog[1] = enc_s(1, 6, 0);                     // sw x6,1(x0)
        prog[2] = enc_s(2, 31, 0);                    // sw x31,2(x0)
        prog[3] = 32'h0000_0073;                      // ecall -> halt
        repeat (2) @(negedge clk);
        #1 reset = 0;
        #1;
        check("restart_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("restart_imem_req", {31'd0, imem_req}, 32'd1);
        check("restart_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 500 && halted !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("x1_cleared", st_wdata[0], 32'd0);
        check("x6_cleared", st_wdata[1], 32'd0);
        check("x31_cleared", st_wdata[2], 32'd0);
        check("ecall_halted", {31'd0, halted}, 32'd1);
        check("ecall_pc", {24'd0, pc}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
